// File: rtl/unimem_pkg.sv
// Shared constants and types for the Unibus memory responder.
package unimem_pkg;

    localparam int          MEMWORDS    = 4096;
    localparam logic [11:0] VERSION     = 12'h001;
    localparam logic [31:0] ID_VALUE    = 32'h4D52_3000 | {20'h0_0000, VERSION};
    localparam logic [31:0] UNUSED_READ = 32'hDEAD_BEEF;
    localparam logic [4:0]  IOPAGE_BASE = 5'b11111;

    localparam logic [1:0] C_DATI  = 2'b00;
    localparam logic [1:0] C_DATIP = 2'b01;
    localparam logic [1:0] C_DATO  = 2'b10;
    localparam logic [1:0] C_DATOB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // DATOB picks the lane from the odd/even byte address; reads write nothing.
    function automatic logic [1:0] byte_en(input logic [1:0] cycle, input logic a0);
        logic [1:0] be;
        be = 2'b00;
        if (cycle == C_DATO)
            be = 2'b11;
        else if (cycle == C_DATOB)
            be = a0 ? 2'b10 : 2'b01;
        return be;
    endfunction

endpackage

// File: rtl/unimem_slave_if.sv
// Unibus slave-side signal bundle: synchronized inputs and OR-ed outputs.
interface unimem_slave_if;
    logic [17:0] addr;
    logic [1:0]  cycle;
    logic [15:0] wdata;
    logic        init;
    logic        msyn;
    logic [15:0] rdata;
    logic        ssyn;

    modport master (output addr, cycle, wdata, init, msyn, input rdata, ssyn);
    modport slave  (input addr, cycle, wdata, init, msyn, output rdata, ssyn);
endinterface

// File: rtl/unimem_ram.sv
// True dual-port word RAM with byte enables and registered read data.
module unimem_ram
    import unimem_pkg::*;
#(
    parameter int WORDS = MEMWORDS,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic [1:0]    we_a,
    input  logic [15:0]   din_a,
    output logic [15:0]   dout_a,
    input  logic [AW-1:0] addr_b,
    input  logic [1:0]    we_b,
    input  logic [15:0]   din_b,
    output logic [15:0]   dout_b
);

    logic [15:0] mem [WORDS];

    // Port A is written last so the bus wins a same-word collision.
    always_ff @(posedge clk) begin
        if (we_b[0]) mem[addr_b][7:0]  <= din_b[7:0];
        if (we_b[1]) mem[addr_b][15:8] <= din_b[15:8];
        if (we_a[0]) mem[addr_a][7:0]  <= din_a[7:0];
        if (we_a[1]) mem[addr_a][15:8] <= din_a[15:8];
        dout_a <= mem[addr_a];
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/unimem_slave.sv
// Unibus memory slave: 8 KB window answered with SSYN, ARM backdoor and counters.
//   state | meaning
//   IDLE  | waiting for MSYN on a window hit; RAM read issued on accept
//   FETCH | RAM data captured (read) or written (DATO/DATOB)
//   RESP  | assert SSYN
//   HOLD  | SSYN held until MSYN drops
module unimem_slave
    import unimem_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    unimem_slave_if.slave  bus,
    input  logic           arm_write,
    input  logic [2:0]     arm_raddr,
    input  logic [2:0]     arm_waddr,
    input  logic [31:0]    arm_wdata,
    output logic [31:0]    arm_rdata
);

    state_t      state;
    logic        enable;
    logic [4:0]  base;
    logic [11:0] arm_addr;
    logic [15:0] dato_count, dati_count;
    logic [12:0] lat_addr;
    logic [1:0]  lat_cycle;
    logic [15:0] lat_data;
    logic        ssyn_q;
    logic [15:0] rdata_q;
    logic [15:0] dout_a, dout_b;

    wire hit = enable && (bus.addr[17:13] == base) && (base != IOPAGE_BASE);
    wire arm_wr_data  = arm_write && (arm_waddr == 3'd2);
    wire arm_clr_cnt  = arm_write && (arm_waddr == 3'd4);
    wire unused_wbits = ^arm_wdata[30:28];

    // In IDLE the RAM is addressed straight from the bus so data is ready in FETCH.
    wire [11:0] ram_addr_a = (state == S_IDLE) ? bus.addr[12:1] : lat_addr[12:1];
    wire [1:0]  ram_we_a   = (state == S_FETCH) ? byte_en(lat_cycle, lat_addr[0]) : 2'b00;
    wire [11:0] ram_addr_b = arm_wr_data ? arm_wdata[27:16] : arm_addr;
    wire [1:0]  ram_we_b   = {2{arm_wr_data && arm_wdata[31]}};

    unimem_ram #(.WORDS(MEMWORDS)) u_ram (
        .clk    (clk),
        .addr_a (ram_addr_a),
        .we_a   (ram_we_a),
        .din_a  (lat_data),
        .dout_a (dout_a),
        .addr_b (ram_addr_b),
        .we_b   (ram_we_b),
        .din_b  (arm_wdata[15:0]),
        .dout_b (dout_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ssyn_q    <= 1'b0;
            rdata_q   <= 16'h0000;
            lat_addr  <= 13'h0000;
            lat_cycle <= C_DATI;
            lat_data  <= 16'h0000;
        end else if (bus.init) begin
            state   <= S_IDLE;
            ssyn_q  <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.msyn && hit) begin
                        lat_addr  <= bus.addr[12:0];
                        lat_cycle <= bus.cycle;
                        lat_data  <= bus.wdata;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!lat_cycle[1])
                        rdata_q <= dout_a;
                    state <= S_RESP;
                end
                S_RESP: begin
                    ssyn_q <= 1'b1;
                    state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (!bus.msyn) begin
                        ssyn_q  <= 1'b0;
                        rdata_q <= 16'h0000;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Counting follows the RAM access, so a write already in FETCH is counted even under INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dato_count <= 16'h0000;
            dati_count <= 16'h0000;
        end else if (arm_clr_cnt) begin
            dato_count <= 16'h0000;
            dati_count <= 16'h0000;
        end else if (state == S_FETCH) begin
            if (lat_cycle[1])
                dato_count <= dato_count + 16'd1;
            else
                dati_count <= dati_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable   <= 1'b0;
            base     <= 5'b00000;
            arm_addr <= 12'h000;
        end else if (arm_write) begin
            if (arm_waddr == 3'd1) begin
                enable <= arm_wdata[31];
                base   <= arm_wdata[4:0];
            end
            if (arm_wr_data)
                arm_addr <= arm_wdata[27:16];
        end
    end

    always_comb begin
        arm_rdata = UNUSED_READ;
        case (arm_raddr)
            3'd0: arm_rdata = ID_VALUE;
            3'd1: arm_rdata = {enable, 26'h0, base};
            3'd2: arm_rdata = {4'h0, arm_addr, 16'h0000};
            3'd3: arm_rdata = {16'h0000, dout_b};
            3'd4: arm_rdata = {dato_count, dati_count};
            default: arm_rdata = UNUSED_READ;
        endcase
    end

    assign bus.ssyn  = ssyn_q;
    assign bus.rdata = rdata_q;

endmodule
